// File: rtl/control_pkg.sv
// rtl/control_pkg.sv - shared control enums for the memory and fetch path
//
// Purpose: memory op encoding, memory bus selector, and fetch FSM states,
// shared by the fetch front end and the memory block.
// Ports: none (package).

`ifndef ADDR_BUS_WIDTH
`define ADDR_BUS_WIDTH 9
`endif

package control;

  typedef enum logic [2:0] {
    NOP      = 3'd0,
    READ     = 3'd1,
    WRITE    = 3'd2,
    INC      = 3'd3,
    ABSOLUTE = 3'd4,
    REL_ADD  = 3'd5,
    REL_SUB  = 3'd6
  } memory_op_e;

  localparam memory_op_e MEMORY_OP_NOP = NOP;

  typedef enum logic {
    BUS_ADDR = 1'b0,
    BUS_PC   = 1'b1
  } memory_bus_selector_e;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH_LO = 3'd1,
    FETCH_HI = 3'd2,
    INC_PC   = 3'd3,
    VALID    = 3'd4,
    JUMP     = 3'd5
  } fetch_state_e;

  // Ops that move the program counter (both in memory and in the shadow copy).
  function automatic logic is_pc_op(memory_op_e op);
    return op inside {INC, ABSOLUTE, REL_ADD, REL_SUB};
  endfunction

  // Only these are accepted as decoder jumps; anything else degrades to NOP.
  function automatic logic is_jump_op(memory_op_e op);
    return op inside {ABSOLUTE, REL_ADD, REL_SUB};
  endfunction

endpackage

// File: rtl/fetch_sequencer_pc_shadow.sv
// rtl/fetch_sequencer_pc_shadow.sv - shadow copy of the memory program counter
//
// Purpose: mirrors memory's PC so the fetch unit knows which address each
// instruction came from. Arithmetic is modulo 2^W.
// Ports:
//   i_clock, i_reset_n : clock, async active-low reset (PC -> 0)
//   i_update           : apply i_op this cycle
//   i_op, i_operand    : INC / ABSOLUTE / REL_ADD / REL_SUB and its 8-bit operand
//   o_pc               : current shadow PC

module pc_shadow
  import control::*;
#(
  parameter int W = `ADDR_BUS_WIDTH
) (
  input  logic         i_clock,
  input  logic         i_reset_n,
  input  logic         i_update,
  input  memory_op_e   i_op,
  input  logic [7:0]   i_operand,
  output logic [W-1:0] o_pc
);

  logic [W-1:0] r_pc;
  logic [W-1:0] w_operand_ext;
  logic [W-1:0] w_next_pc;

  assign w_operand_ext = W'(i_operand);

  always_comb begin
    w_next_pc = r_pc;
    case (i_op)
      INC:      w_next_pc = r_pc + W'(1);
      ABSOLUTE: w_next_pc = w_operand_ext;
      REL_ADD:  w_next_pc = r_pc + w_operand_ext;
      REL_SUB:  w_next_pc = r_pc - w_operand_ext;
      default:  w_next_pc = r_pc;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pc <= '0;
    end else if (i_update) begin
      r_pc <= w_next_pc;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch front end driving memory's op port
//
// Purpose: reads the two-byte instruction at PC (low then high byte), bumps
// PC, and hands {hi, lo} to the decoder over a valid/ready handshake.
// Decoder jumps are forwarded to memory through the same op port.
// Ports:
//   clock, reset              : clock, async active-low reset
//   run                       : level enable for fetching
//   mem_op, mem_bus_selector,
//   mem_data_word_selector,
//   mem_in, mem_out           : memory control / data
//   instr_valid/ready, instr,
//   instr_pc                  : decoder instruction handshake
//   jump_valid/ready,
//   jump_kind, jump_operand   : decoder jump handshake

module fetch_sequencer
  import control::*;
(
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       run,
  output memory_op_e                 mem_op,
  output memory_bus_selector_e       mem_bus_selector,
  output logic                       mem_data_word_selector,
  output logic [7:0]                 mem_in,
  input  logic [7:0]                 mem_out,
  output logic                       instr_valid,
  input  logic                       instr_ready,
  output logic [15:0]                instr,
  output logic [`ADDR_BUS_WIDTH-1:0] instr_pc,
  input  logic                       jump_valid,
  output logic                       jump_ready,
  input  memory_op_e                 jump_kind,
  input  logic [7:0]                 jump_operand
);

  localparam int AW = `ADDR_BUS_WIDTH;

  fetch_state_e         r_state;
  fetch_state_e         w_next_state;
  memory_op_e           r_mem_op;
  memory_op_e           w_next_mem_op;
  memory_bus_selector_e r_bus_sel;
  logic                 r_word_sel;
  logic [7:0]           r_mem_in;
  logic [7:0]           w_next_mem_in;
  logic                 r_instr_valid;
  logic                 r_jump_ready;
  logic [15:0]          r_instr;
  logic [AW-1:0]        r_instr_pc;
  logic [AW-1:0]        w_pc;

  // The registered op/operand double as the latched jump kind/operand, so the
  // shadow PC applies exactly what memory sees on the same edge.
  pc_shadow #(.W(AW)) u_pc_shadow (
    .i_clock   (clock),
    .i_reset_n (reset),
    .i_update  (is_pc_op(r_mem_op)),
    .i_op      (r_mem_op),
    .i_operand (r_mem_in),
    .o_pc      (w_pc)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:     if (run) w_next_state = FETCH_LO;
      FETCH_LO: w_next_state = FETCH_HI;
      FETCH_HI: w_next_state = INC_PC;
      INC_PC:   w_next_state = VALID;
      VALID: begin
        if (jump_valid)       w_next_state = JUMP;
        else if (instr_ready) w_next_state = run ? FETCH_LO : IDLE;
      end
      JUMP:     w_next_state = run ? FETCH_LO : IDLE;
      default:  w_next_state = IDLE;
    endcase
  end

  // Outputs are decoded from the state being entered and registered, so no
  // handshake input reaches an output combinationally.
  always_comb begin
    w_next_mem_op = NOP;
    w_next_mem_in = 8'h00;
    case (w_next_state)
      FETCH_LO, FETCH_HI: w_next_mem_op = READ;
      INC_PC:             w_next_mem_op = INC;
      JUMP: begin
        // JUMP is only entered from VALID, so jump_kind is current here.
        if (is_jump_op(jump_kind)) begin
          w_next_mem_op = jump_kind;
          w_next_mem_in = jump_operand;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_mem_op      <= NOP;
      r_bus_sel     <= BUS_ADDR;
      r_word_sel    <= 1'b0;
      r_mem_in      <= 8'h00;
      r_instr_valid <= 1'b0;
      r_jump_ready  <= 1'b0;
      r_instr       <= 16'h0000;
      r_instr_pc    <= '0;
    end else begin
      r_state       <= w_next_state;
      r_mem_op      <= w_next_mem_op;
      r_bus_sel     <= (w_next_mem_op != NOP) ? BUS_PC : BUS_ADDR;
      r_word_sel    <= (w_next_state == FETCH_HI);
      r_mem_in      <= w_next_mem_in;
      r_instr_valid <= (w_next_state == VALID);
      r_jump_ready  <= (w_next_state == VALID);
      // Read data lands one cycle after the READ is issued.
      if (r_state == FETCH_HI) r_instr[7:0] <= mem_out;
      if (r_state == INC_PC) begin
        r_instr[15:8] <= mem_out;
        r_instr_pc    <= w_pc;
      end
    end
  end

  assign mem_op                 = r_mem_op;
  assign mem_bus_selector       = r_bus_sel;
  assign mem_data_word_selector = r_word_sel;
  assign mem_in                 = r_mem_in;
  assign instr_valid            = r_instr_valid;
  assign jump_ready             = r_jump_ready;
  assign instr                  = r_instr;
  assign instr_pc               = r_instr_pc;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench for fetch_sequencer

`timescale 1ns/1ps
`ifndef ADDR_BUS_WIDTH
`define ADDR_BUS_WIDTH 9
`endif

module tb_fetch_sequencer;
  import control::*;

  localparam int AW     = `ADDR_BUS_WIDTH;
  localparam int PC_MOD = 1 << AW;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic                 run = 1'b0;
  memory_op_e           mem_op;
  memory_bus_selector_e mem_bus_selector;
  logic                 mem_data_word_selector;
  logic [7:0]           mem_in;
  logic [7:0]           mem_out;
  logic                 instr_valid;
  logic                 instr_ready = 1'b0;
  logic [15:0]          instr;
  logic [AW-1:0]        instr_pc;
  logic                 jump_valid = 1'b0;
  logic                 jump_ready;
  memory_op_e           jump_kind = NOP;
  logic [7:0]           jump_operand = 8'h00;

  int checks = 0;
  int errors = 0;
  int exp_pc = 0;

  always #5 clock = ~clock;

  fetch_sequencer dut (
    .clock                  (clock),
    .reset                  (reset),
    .run                    (run),
    .mem_op                 (mem_op),
    .mem_bus_selector       (mem_bus_selector),
    .mem_data_word_selector (mem_data_word_selector),
    .mem_in                 (mem_in),
    .mem_out                (mem_out),
    .instr_valid            (instr_valid),
    .instr_ready            (instr_ready),
    .instr                  (instr),
    .instr_pc               (instr_pc),
    .jump_valid             (jump_valid),
    .jump_ready             (jump_ready),
    .jump_kind              (jump_kind),
    .jump_operand           (jump_operand)
  );

  // Behavioural memory: byte pairs per address, own PC, synchronous reset.
  logic [7:0] lo_mem [PC_MOD];
  logic [7:0] hi_mem [PC_MOD];
  int mem_pc = 0;

  always @(posedge clock) begin
    if (!reset) begin
      mem_pc <= 0;
    end else begin
      case (mem_op)
        READ:     mem_out <= mem_data_word_selector ? hi_mem[mem_pc] : lo_mem[mem_pc];
        INC:      mem_pc <= (mem_pc + 1) % PC_MOD;
        ABSOLUTE: mem_pc <= int'(mem_in);
        REL_ADD:  mem_pc <= (mem_pc + int'(mem_in)) % PC_MOD;
        REL_SUB:  mem_pc <= (mem_pc + PC_MOD - int'(mem_in)) % PC_MOD;
        default:  ;
      endcase
    end
  end

  // Bus selector / operand rules checked every cycle out of reset.
  always @(negedge clock) begin
    if (reset) begin
      checks++;
      if ((mem_op != NOP) !== (mem_bus_selector == BUS_PC)) begin
        errors++;
        $display("FAIL bus_sel: op=%0d sel=%0d", mem_op, mem_bus_selector);
      end
      checks++;
      if (!(mem_op inside {ABSOLUTE, REL_ADD, REL_SUB}) && mem_in !== 8'h00) begin
        errors++;
        $display("FAIL mem_in_idle: op=%0d mem_in=%0h expected 0", mem_op, mem_in);
      end
    end
  end

  // Next instruction address given the shadow PC after INC.
  function automatic int model_next(int shadow, bit jv, memory_op_e k, int opnd);
    if (!jv) return shadow;
    case (k)
      ABSOLUTE: return opnd;
      REL_ADD:  return (shadow + opnd) % PC_MOD;
      REL_SUB:  return (shadow + PC_MOD - opnd) % PC_MOD;
      default:  return shadow;
    endcase
  endfunction

  function automatic logic [15:0] model_word(int pc);
    return {hi_mem[pc], lo_mem[pc]};
  endfunction

  // Stimulus only: from a VALID negedge, hand over consume/jump, capture the
  // op seen in the following cycle and the cycles until the next instr_valid.
  task automatic do_step(input bit jv, input memory_op_e k, input logic [7:0] opnd,
                         input bit rdy, output memory_op_e seen_op,
                         output logic [7:0] seen_in, output int lat);
    jump_valid   = jv;
    jump_kind    = k;
    jump_operand = opnd;
    instr_ready  = jv ? rdy : 1'b1;
    @(negedge clock);
    jump_valid  = 1'b0;
    instr_ready = 1'b0;
    seen_op = mem_op;
    seen_in = mem_in;
    lat = 0;
    while (!instr_valid && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    if (!instr_valid) lat = -1;
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    checks++; if (mem_op !== NOP) begin errors++; $display("FAIL reset_op: got %0d expected NOP", mem_op); end
    checks++; if (mem_bus_selector !== BUS_ADDR || mem_data_word_selector !== 1'b0 || mem_in !== 8'h00) begin
      errors++; $display("FAIL reset_mem: sel=%0d word=%0d in=%0h expected 0", mem_bus_selector, mem_data_word_selector, mem_in); end
    checks++; if (instr_valid !== 1'b0 || jump_ready !== 1'b0) begin
      errors++; $display("FAIL reset_hs: valid=%0d jready=%0d expected 0", instr_valid, jump_ready); end
    checks++; if (instr !== 16'h0000 || instr_pc !== '0) begin
      errors++; $display("FAIL reset_instr: instr=%0h pc=%0h expected 0", instr, instr_pc); end
  endtask

  task automatic test_first_fetch();
    int n;
    reset = 1'b1; run = 1'b1; instr_ready = 1'b1;
    n = 0;
    while (mem_op !== READ && n < 20) begin @(negedge clock); n++; end
    checks++; if (mem_op !== READ) begin errors++; $display("FAIL first_fetch_start: op=%0d expected READ", mem_op); end
    n = 0;
    while (!instr_valid && n < 20) begin @(negedge clock); n++; end
    checks++; if (n != 3) begin errors++; $display("FAIL fetch_latency: got %0d expected 3", n); end
    checks++; if (instr !== 16'h1234) begin errors++; $display("FAIL first_instr: got %0h expected 1234", instr); end
    checks++; if (instr_pc !== '0) begin errors++; $display("FAIL first_pc: got %0h expected 0", instr_pc); end
    n = 0;
    do begin @(negedge clock); n++; end while (!instr_valid && n < 20);
    instr_ready = 1'b0;
    checks++; if (n != 4) begin errors++; $display("FAIL throughput: got %0d expected 4", n); end
    checks++; if (instr_pc !== AW'(1) || instr !== model_word(1)) begin
      errors++; $display("FAIL second_instr: pc=%0h instr=%0h expected pc 1 instr %0h", instr_pc, instr, model_word(1)); end
    exp_pc = 1;
  endtask

  task automatic test_hold();
    logic [15:0] held;
    memory_op_e sop; logic [7:0] sin; int lat;
    held = instr;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checks++;
      if (instr_valid !== 1'b1 || jump_ready !== 1'b1 || instr !== held || instr_pc !== AW'(exp_pc) || mem_op !== NOP) begin
        errors++;
        $display("FAIL hold_%0d: valid=%0d jready=%0d instr=%0h pc=%0h op=%0d expected 1 1 %0h %0h NOP",
                 i, instr_valid, jump_ready, instr, instr_pc, mem_op, held, exp_pc);
      end
    end
    checks++; if (mem_pc != 2) begin errors++; $display("FAIL hold_no_inc: memory pc=%0d expected 2", mem_pc); end
    do_step(1'b0, NOP, 8'h00, 1'b1, sop, sin, lat);
    exp_pc = model_next((exp_pc + 1) % PC_MOD, 1'b0, NOP, 0);
    checks++; if (instr_pc !== AW'(exp_pc) || instr !== model_word(exp_pc)) begin
      errors++; $display("FAIL after_hold: pc=%0h instr=%0h expected %0h %0h", instr_pc, instr, exp_pc, model_word(exp_pc)); end
  endtask

  task automatic test_rel_sub();
    memory_op_e sop; logic [7:0] sin; int lat;
    do_step(1'b1, ABSOLUTE, 8'h04, 1'b0, sop, sin, lat);
    exp_pc = model_next((exp_pc + 1) % PC_MOD, 1'b1, ABSOLUTE, 4);
    checks++; if (sop !== ABSOLUTE || sin !== 8'h04) begin errors++; $display("FAIL abs4_op: op=%0d in=%0h expected ABSOLUTE 04", sop, sin); end
    checks++; if (lat != 4) begin errors++; $display("FAIL jump_latency: got %0d expected 4", lat); end
    checks++; if (instr_pc !== AW'(4)) begin errors++; $display("FAIL abs4_pc: got %0h expected 4", instr_pc); end
    do_step(1'b1, REL_SUB, 8'h03, 1'b0, sop, sin, lat);
    exp_pc = model_next((exp_pc + 1) % PC_MOD, 1'b1, REL_SUB, 3);
    checks++; if (sop !== REL_SUB || sin !== 8'h03) begin errors++; $display("FAIL relsub_op: op=%0d in=%0h expected REL_SUB 03", sop, sin); end
    checks++; if (lat != 4) begin errors++; $display("FAIL relsub_latency: got %0d expected 4", lat); end
    checks++; if (instr_pc !== AW'(2) || instr !== model_word(2)) begin
      errors++; $display("FAIL relsub_pc: pc=%0h instr=%0h expected 2 %0h", instr_pc, instr, model_word(2)); end
  endtask

  task automatic test_abs_with_ready();
    memory_op_e sop; logic [7:0] sin; int lat;
    do_step(1'b1, ABSOLUTE, 8'hF0, 1'b1, sop, sin, lat);
    exp_pc = model_next((exp_pc + 1) % PC_MOD, 1'b1, ABSOLUTE, 'hF0);
    checks++; if (sop !== ABSOLUTE || sin !== 8'hF0) begin errors++; $display("FAIL absf0_op: op=%0d in=%0h expected ABSOLUTE f0", sop, sin); end
    checks++; if (lat != 4) begin errors++; $display("FAIL absf0_latency: got %0d expected 4", lat); end
    checks++; if (instr_pc !== AW'('h0F0) || instr !== model_word('hF0)) begin
      errors++; $display("FAIL absf0_pc: pc=%0h instr=%0h expected 0f0 %0h", instr_pc, instr, model_word('hF0)); end
  endtask

  task automatic test_wrap();
    bit         jvs  [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    memory_op_e ks   [6] = '{ABSOLUTE, REL_ADD, NOP, ABSOLUTE, REL_ADD, REL_ADD};
    int         ops  [6] = '{'hFF, 'hFF, 0, 'h7F, 'hFF, 'hFF};
    int         pcs  [6] = '{'h0FF, 'h1FF, 'h000, 'h07F, 'h17F, 'h07F};
    memory_op_e sop; logic [7:0] sin; int lat;
    for (int i = 0; i < 6; i++) begin
      do_step(jvs[i], ks[i], 8'(ops[i]), 1'b0, sop, sin, lat);
      exp_pc = model_next((exp_pc + 1) % PC_MOD, jvs[i], ks[i], ops[i]);
      checks++;
      if (instr_pc !== AW'(exp_pc) || instr_pc !== AW'(pcs[i]) || instr !== model_word(exp_pc)) begin
        errors++;
        $display("FAIL wrap_%0d: pc=%0h instr=%0h expected %0h %0h", i, instr_pc, instr, pcs[i], model_word(exp_pc));
      end
    end
  endtask

  task automatic test_run_gating();
    int n;
    run = 1'b0; instr_ready = 1'b1;
    @(negedge clock);
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mem_op !== NOP || instr_valid !== 1'b0) begin
        errors++; $display("FAIL idle_%0d: op=%0d valid=%0d expected NOP 0", i, mem_op, instr_valid); end
      @(negedge clock);
    end
    run = 1'b1;
    n = 0;
    while (mem_op !== READ && n < 20) begin @(negedge clock); n++; end
    run = 1'b0;
    n = 0;
    while (!instr_valid && n < 20) begin @(negedge clock); n++; end
    exp_pc = (exp_pc + 1) % PC_MOD;
    checks++; if (n != 3 || instr_pc !== AW'(exp_pc)) begin
      errors++; $display("FAIL run_midfetch: lat=%0d pc=%0h expected 3 %0h", n, instr_pc, exp_pc); end
    run = 1'b1;
  endtask

  task automatic test_random();
    memory_op_e k, sop, eop; logic [7:0] opnd, sin, ein; int lat, hold; bit jv, rdy;
    for (int it = 0; it < 40; it++) begin
      hold = $urandom_range(0, 2);
      for (int h = 0; h < hold; h++) begin
        @(negedge clock);
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== AW'(exp_pc)) begin
          errors++; $display("FAIL rnd_hold_%0d: valid=%0d pc=%0h expected 1 %0h", it, instr_valid, instr_pc, exp_pc); end
      end
      jv   = ($urandom_range(0, 2) == 0);
      k    = memory_op_e'(3'($urandom_range(0, 7)));
      opnd = 8'($urandom);
      rdy  = 1'($urandom_range(0, 1));
      eop  = (k inside {ABSOLUTE, REL_ADD, REL_SUB}) ? k : NOP;
      ein  = (eop != NOP) ? opnd : 8'h00;
      do_step(jv, k, opnd, rdy, sop, sin, lat);
      exp_pc = model_next((exp_pc + 1) % PC_MOD, jv, k, int'(opnd));
      if (jv) begin
        checks++;
        if (sop !== eop || sin !== ein) begin
          errors++; $display("FAIL rnd_jump_%0d: op=%0d in=%0h expected %0d %0h", it, sop, sin, eop, ein); end
      end
      checks++;
      if (lat != (jv ? 4 : 3) || instr_pc !== AW'(exp_pc) || instr !== model_word(exp_pc)) begin
        errors++;
        $display("FAIL rnd_instr_%0d: lat=%0d pc=%0h instr=%0h expected %0d %0h %0h",
                 it, lat, instr_pc, instr, jv ? 4 : 3, exp_pc, model_word(exp_pc));
      end
    end
  endtask

  task automatic test_async_reset();
    int n;
    instr_ready = 1'b1;
    @(negedge clock);
    instr_ready = 1'b0;
    @(negedge clock);
    checks++; if (mem_data_word_selector !== 1'b1 || mem_op !== READ) begin
      errors++; $display("FAIL pre_reset_fetch_hi: word=%0d op=%0d expected 1 READ", mem_data_word_selector, mem_op); end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (mem_op !== NOP || mem_bus_selector !== BUS_ADDR || mem_data_word_selector !== 1'b0 ||
        instr_valid !== 1'b0 || jump_ready !== 1'b0 || instr !== 16'h0000 || instr_pc !== '0) begin
      errors++;
      $display("FAIL async_reset: op=%0d sel=%0d word=%0d valid=%0d jr=%0d instr=%0h pc=%0h expected all 0",
               mem_op, mem_bus_selector, mem_data_word_selector, instr_valid, jump_ready, instr, instr_pc);
    end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    n = 0;
    while (!instr_valid && n < 20) begin @(negedge clock); n++; end
    checks++; if (instr_valid !== 1'b1 || instr_pc !== '0 || instr !== 16'h1234) begin
      errors++; $display("FAIL refetch: valid=%0d pc=%0h instr=%0h expected 1 0 1234", instr_valid, instr_pc, instr); end
  endtask

  initial begin
    for (int i = 0; i < PC_MOD; i++) begin
      lo_mem[i] = 8'($urandom);
      hi_mem[i] = 8'($urandom);
    end
    lo_mem[0] = 8'h34;
    hi_mem[0] = 8'h12;
    test_reset();
    test_first_fetch();
    test_hold();
    test_rel_sub();
    test_abs_with_ready();
    test_wrap();
    test_run_gating();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction fetch front end sitting directly upstream of `memory`. Drives `memory`'s op/bus/word-select controls to read the two-byte instruction at PC, tracks a shadow copy of PC, and presents the instruction to the decoder through a valid/ready handshake. Also applies decoder-issued jumps (absolute or relative) to PC through the same memory op port.

## Interface
- `ADDR_BUS_WIDTH`, from `` `ADDR_BUS_WIDTH``: PC width; shadow PC matches `memory`.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `run` in 1: level; 1 lets the sequencer leave IDLE and keep fetching.
- `mem_op` out `memory_op_e`: op to `memory`.
- `mem_bus_selector` out `memory_bus_selector_e`: always PC (1) when `mem_op` ≠ NOP, else 0.
- `mem_data_word_selector` out 1: 0 = low byte, 1 = high byte.
- `mem_in` out 8: operand for ABSOLUTE/REL_ADD/REL_SUB, else 0.
- `mem_out` in 8: read data from `memory`.
- `instr_valid` out 1, `instr_ready` in 1: decoder handshake.
- `instr` out 16: {high byte, low byte}.
- `instr_pc` out `ADDR_BUS_WIDTH`: PC the instruction was fetched from.
- `jump_valid` in 1, `jump_ready` out 1: jump handshake.
- `jump_kind` in `memory_op_e`: ABSOLUTE, REL_ADD or REL_SUB only.
- `jump_operand` in 8: target or offset.

## Operation
- States: IDLE, FETCH_LO, FETCH_HI, INC_PC, VALID, JUMP.
- IDLE: `mem_op`=NOP. Goes to FETCH_LO when `run`=1.
- FETCH_LO: `mem_op`=READ, word 0. Always goes to FETCH_HI.
- FETCH_HI: `mem_op`=READ, word 1. Captures `mem_out` into `instr[7:0]`. Always goes to INC_PC.
- INC_PC: `mem_op`=INC. Captures `mem_out` into `instr[15:8]`. Latches `instr_pc`=shadow PC, then shadow PC += 1. Goes to VALID.
- VALID: `instr_valid`=1, `jump_ready`=1, `mem_op`=NOP. Transitions:
  - `jump_valid`=1 goes to JUMP. Latch kind/operand. If `instr_ready`=1 in the same cycle, the instruction is also consumed; the jump still wins.
  - Else `instr_ready`=1 goes to FETCH_LO if `run`, else IDLE.
  - Else stay; `instr`/`instr_pc` are held stable.
- JUMP: `mem_op`=latched kind, `mem_in`=latched operand. Shadow PC updates identically. Goes to FETCH_LO if `run`, else IDLE.
- Shadow PC arithmetic is modulo 2^`ADDR_BUS_WIDTH`:
  - ABSOLUTE: {0, operand}.
  - REL_ADD / REL_SUB: PC ± zero-extended operand.
  - INC: +1; wraps from all-ones to 0.
- An illegal `jump_kind` is treated as NOP: PC unchanged, state still returns to fetch.
- `run` deasserted mid-fetch: the current fetch completes up to VALID. `run` is only sampled in IDLE, on VALID exit and on JUMP exit.

## Timing
- Reset (async assert): state=IDLE; shadow PC=0, matching `memory`'s PC reset. All outputs 0, `mem_op`=NOP.
- Reset mid-fetch aborts with no partial `instr_valid`. Top level holds `memory`'s synchronous reset for ≥1 clock edge over the same interval.
- `memory` updates `mem_out` at the edge where READ is sampled. Data is valid for the whole following cycle and is sampled at that cycle's end.
- Fetch latency: FETCH_LO entry to `instr_valid`=1 is 3 cycles.
- Back-to-back throughput: 4 cycles per instruction with `instr_ready` tied high.
- Jump cost: JUMP (1 cycle) + 3-cycle fetch.
- Outputs are registered or pure state decodes; no combinational path from `instr_ready`/`jump_valid` to any output.

## Structure
- `fetch_state_e` goes in the shared `control` package, next to `memory_op_e` and `memory_bus_selector_e`. `control` also provides the NOP encoding of `memory_op_e`.
- `` `ADDR_BUS_WIDTH`` stays the existing global define.
- One sub-module: `pc_shadow` holds the shadow PC register and performs the INC/ABSOLUTE/REL_ADD/REL_SUB arithmetic. It has an update strobe and an op input.

## Test plan
- Reset, `run`=1, memory preloaded: word0@0=0x34, word1@0=0x12, `instr_ready`=1 → `instr_valid` 3 cycles after FETCH_LO with `instr`=0x1234, `instr_pc`=0; next instruction from PC 1.
- `instr_ready`=0 for 5 cycles in VALID → `instr` and `instr_pc` held, `mem_op`=NOP every cycle, no extra INC.
- At PC 5, jump REL_SUB 3 → `mem_op`=REL_SUB, `mem_in`=3 for one cycle; next `instr_pc`=2.
- Jump ABSOLUTE 0xF0 with `instr_ready`=1 in the same cycle → one JUMP cycle, instruction consumed, next `instr_pc`=0x0F0.
- Shadow PC at all-ones, fetch completes → INC wraps; next `instr_pc`=0. REL_ADD 0xFF from PC 0x180 wraps modulo 2^`ADDR_BUS_WIDTH`.
- `reset` asserted asynchronously during FETCH_HI → outputs 0 immediately, not waiting for a clock edge. After release with `run`=1, refetch from PC 0.
